// File: rtl/data_mem.sv
// Byte-addressable data memory for the core's memory stage. After reset it zeroes
// itself one word per cycle, then serves RV-style B/H/W loads and stores.
module data_mem #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_mem_write,
  input  logic        i_mem_read,
  input  logic [2:0]  i_mem_size,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_misalign,
  output logic [31:0] o_err_addr,
  output logic [31:0] o_load_cnt,
  output logic [31:0] o_store_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic            r_misalign;
  logic [31:0]     r_err_addr;
  logic [31:0]     r_load_cnt;
  logic [31:0]     r_store_cnt;

  logic [AW-1:0]   w_idx;
  logic            w_size_ok;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_unsigned;
  logic            w_misal;
  logic            w_access;
  logic            w_store_do;
  logic            w_load_do;
  logic            w_flag_set;
  logic [31:0]     w_rword;
  logic [7:0]      w_lane_b;
  logic [15:0]     w_lane_h;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wdata;

  // Upper address bits are deliberately dropped, so the array aliases.
  assign w_idx   = i_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_size_ok  = 1'b1;
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_unsigned = 1'b0;
    case (i_mem_size)
      3'b000: w_is_byte = 1'b1;
      3'b001: w_is_half = 1'b1;
      3'b010: w_is_word = 1'b1;
      3'b100: begin
        w_is_byte  = 1'b1;
        w_unsigned = 1'b1;
      end
      3'b101: begin
        w_is_half  = 1'b1;
        w_unsigned = 1'b1;
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_misal    = w_size_ok &&
                      ((w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00)));
  assign w_access   = (r_state == RUN) && w_size_ok;
  assign w_store_do = w_access && i_mem_write && !w_misal;
  assign w_load_do  = w_access && i_mem_read && !i_mem_write && !w_misal;
  assign w_flag_set = w_access && (i_mem_read || i_mem_write) && w_misal && !r_misalign;

  assign w_lane_b = w_rword[8*i_addr[1:0] +: 8];
  assign w_lane_h = i_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    o_read_data = 32'h0;
    if ((r_state == RUN) && w_size_ok && !w_misal) begin
      if (w_is_byte)
        o_read_data = w_unsigned ? {24'h0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
      else if (w_is_half)
        o_read_data = w_unsigned ? {16'h0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
      else
        o_read_data = w_rword;
    end
  end

  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = i_write_data;
    if (w_is_byte) begin
      w_wmask = 4'b0001 << i_addr[1:0];
      w_wdata = {4{i_write_data[7:0]}};
    end else if (w_is_half) begin
      w_wmask = i_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_write_data[15:0]}};
    end else if (w_is_word) begin
      w_wmask = 4'b1111;
    end
  end

  // Array has no reset; the CLEAR sweep is what guarantees zero contents.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_idx] <= 32'h0;
      end else if (w_store_do) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wmask[b])
            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR)
        r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_clr_idx == AW'(DEPTH_WORDS - 1))
          w_state_nxt = RUN;
      end
      RUN: o_ready = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_misalign  <= 1'b0;
      r_err_addr  <= 32'h0;
      r_load_cnt  <= 32'h0;
      r_store_cnt <= 32'h0;
    end else begin
      if (w_flag_set) begin
        r_misalign <= 1'b1;
        r_err_addr <= i_addr;
      end
      if (w_store_do)
        r_store_cnt <= r_store_cnt + 32'd1;
      if (w_load_do)
        r_load_cnt <= r_load_cnt + 32'd1;
    end
  end

  assign o_misalign  = r_misalign;
  assign o_err_addr  = r_err_addr;
  assign o_load_cnt  = r_load_cnt;
  assign o_store_cnt = r_store_cnt;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (DEPTH_WORDS=16): load results go through a
// scoreboard queue; flags and counters are checked against a small bench model.
module tb_data_mem;

  localparam int DEPTH = 16;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic        clk_sys;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_size;
  logic [31:0] read_data;
  logic        ready;
  logic        misalign;
  logic [31:0] err_addr;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_load_cnt;
  logic [31:0] exp_store_cnt;
  logic [31:0] sb_q [$];

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk        (clk_sys),
    .i_reset      (reset),
    .i_addr       (addr),
    .i_write_data (write_data),
    .i_mem_write  (mem_write),
    .i_mem_read   (mem_read),
    .i_mem_size   (mem_size),
    .o_read_data  (read_data),
    .o_ready      (ready),
    .o_misalign   (misalign),
    .o_err_addr   (err_addr),
    .o_load_cnt   (load_cnt),
    .o_store_cnt  (store_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_aligned(input logic [31:0] a, input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: return 1'b1;
      SZ_H, SZ_HU: return !a[0];
      SZ_W:        return a[1:0] == 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] exp);
    addr = a; mem_size = sz; mem_read = 1'b1; mem_write = 1'b0;
    sb_q.push_back(exp);
    #1;
    chk(tag, read_data, sb_q.pop_front());
    if (is_aligned(a, sz)) exp_load_cnt++;
    @(negedge clk_sys);
    mem_read = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr = a; mem_size = sz; write_data = d; mem_write = 1'b1; mem_read = 1'b0;
    if (is_aligned(a, sz)) exp_store_cnt++;
    @(negedge clk_sys);
    mem_write = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_store_cnt"}, store_cnt, exp_store_cnt);
    chk({tag, "_load_cnt"}, load_cnt, exp_load_cnt);
  endtask

  // Releases reset and walks the sweep while hammering a store at word 0;
  // read_data must stay 0 and the store must be dropped.
  task automatic sweep(input string tag);
    reset = 1'b0;
    addr = 32'h0; mem_size = SZ_W; write_data = 32'hDEADBEEF;
    mem_write = 1'b1; mem_read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk({tag, "_ready_low"}, {31'h0, ready}, 32'h0);
      chk({tag, "_clear_rd"}, read_data, 32'h0);
      @(negedge clk_sys);
    end
    mem_write = 1'b0; mem_read = 1'b0;
    #1;
    chk({tag, "_ready_high"}, {31'h0, ready}, 32'h1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    exp_load_cnt = 0; exp_store_cnt = 0;
    reset = 1'b1; addr = 0; write_data = 0; mem_write = 0; mem_read = 0; mem_size = SZ_W;
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk_counters("rst");

    sweep("init");
    @(negedge clk_sys);
    for (int i = 0; i < DEPTH; i++) do_load("zero_word", 32'(i * 4), SZ_W, 32'h0);
    exp_load_cnt = 0;
    reset = 1'b1;
    @(negedge clk_sys);
    sweep("init2");
    @(negedge clk_sys);

    // Partial-lane stores preserve neighbouring bytes.
    do_store(32'h4, SZ_W, 32'h11223344);
    do_store(32'h5, SZ_B, 32'hFFFFFFAA);
    do_load("sb_merge", 32'h4, SZ_W, 32'h1122AA44);
    do_store(32'h6, SZ_H, 32'h0000BEEF);
    do_load("sh_merge", 32'h4, SZ_W, 32'hBEEFAA44);
    chk("store_cnt_3", store_cnt, 32'd3);

    // Load extension on every lane.
    do_store(32'h8, SZ_W, 32'h80FF7F01);
    do_load("lb_8", 32'h8, SZ_B, 32'h00000001);
    do_load("lb_9", 32'h9, SZ_B, 32'h0000007F);
    do_load("lb_b", 32'hB, SZ_B, 32'hFFFFFF80);
    do_load("lbu_a", 32'hA, SZ_BU, 32'h000000FF);
    do_load("lh_a", 32'hA, SZ_H, 32'hFFFF80FF);
    do_load("lhu_a", 32'hA, SZ_HU, 32'h000080FF);
    do_load("lh_8", 32'h8, SZ_H, 32'h00007F01);
    chk_counters("ext");

    // Same-cycle store+load: old data now, new data next cycle, counted as store only.
    addr = 32'h4; mem_size = SZ_W; write_data = 32'hCAFEF00D;
    mem_write = 1'b1; mem_read = 1'b1;
    exp_store_cnt++;
    sb_q.push_back(32'hBEEFAA44);
    #1;
    chk("rw_old", read_data, sb_q.pop_front());
    @(negedge clk_sys);
    mem_write = 1'b0; mem_read = 1'b0;
    do_load("rw_new", 32'h4, SZ_W, 32'hCAFEF00D);
    do_load("alias_44", 32'h44, SZ_W, 32'hCAFEF00D);
    do_load("lhu_6", 32'h6, SZ_HU, 32'h0000CAFE);
    do_load("lb_7", 32'h7, SZ_B, 32'hFFFFFFCA);
    chk_counters("rw");

    // Misalignment: store suppressed, load returns 0, first address sticks.
    do_store(32'h6, SZ_W, 32'h12345678);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    chk("mis_err_addr", err_addr, 32'h6);
    do_load("mis_lh", 32'h3, SZ_H, 32'h0);
    chk("mis_err_sticky", err_addr, 32'h6);
    do_load("mis_mem4", 32'h4, SZ_W, 32'hCAFEF00D);
    do_load("mis_mem8", 32'h8, SZ_W, 32'h80FF7F01);
    chk_counters("mis");

    // Invalid size codes do nothing.
    do_store(32'h0, 3'b011, 32'hFFFFFFFF);
    do_load("inv_ld", 32'h4, 3'b110, 32'h0);
    do_load("inv_mem0", 32'h0, SZ_W, 32'h0);
    chk_counters("inv");

    // Reset five cycles into a sweep restarts it from index 0.
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("rst2_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk_sys);
    exp_load_cnt = 0; exp_store_cnt = 0;
    chk("rst2_err_addr", err_addr, 32'h0);
    chk_counters("rst2");
    sweep("resweep");
    @(negedge clk_sys);
    do_load("resweep_w0", 32'h0, SZ_W, 32'h0);
    do_load("resweep_w1", 32'h4, SZ_W, 32'h0);
    do_load("resweep_w2", 32'h8, SZ_W, 32'h0);
    exp_load_cnt = 3;
    chk_counters("resweep");

    // Store counter wrap.
    force dut.r_store_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_store_cnt;
    @(negedge clk_sys);
    exp_store_cnt = 32'hFFFFFFFF;
    do_store(32'h10, SZ_W, 32'h1);
    chk("wrap_0", store_cnt, 32'h0);
    do_store(32'h14, SZ_W, 32'h2);
    chk("wrap_1", store_cnt, 32'h1);
    chk("wrap_model", store_cnt, exp_store_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
